// File: rtl/ledg_fade_driver_pkg.sv
// Shared constants and types for the green-LED PWM/fade driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ledg_pkg;

    localparam int LEDG_NUM_LEDS = 9;
    localparam int LEDG_LEVEL_W  = 4;

    typedef logic [LEDG_LEVEL_W-1:0] ledg_level_t;

endpackage

// File: rtl/ledg_fade_channel.sv
// One LED channel: level register that tracks the requested brightness and a registered PWM compare.
// Latency: request -> level 1 clk (immediate mode) or on fade_tick (LEDG_FADE_EN); level -> ledg 1 clk.
// Backpressure: none, inputs are level-valued and sampled every clock.
module ledg_fade_channel #(
    parameter int LEVEL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic [LEVEL_W-1:0] brightness,
    input  logic               fade_tick,
    input  logic [LEVEL_W-1:0] pwm_cnt,
    output logic               ledg
);

    logic [LEVEL_W-1:0] target;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;
    logic               ledg_q;

    assign target = req ? brightness : '0;

    // Next level: one step toward the target per fade tick, or jump straight to it.
    always_comb begin
        level_d = level_q;
`ifdef LEDG_FADE_EN
        // Target always lies in 0..LMAX, so a +/-1 step toward it can never wrap.
        if (fade_tick) begin
            if (level_q < target) begin
                level_d = level_q + 1'b1;
            end else if (level_q > target) begin
                level_d = level_q - 1'b1;
            end
        end
`else
        level_d = target;
`endif
    end

`ifndef LEDG_FADE_EN
    // Tick is tied low by the top in this build; kept on the port so the wiring is identical.
    logic unused_fade_tick;
    assign unused_fade_tick = fade_tick;
`endif

    // Level register and PWM compare; pwm_cnt never reaches LMAX so full level is always lit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            ledg_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            ledg_q  <= (level_q > pwm_cnt);
        end
    end

    assign ledg = ledg_q;

endmodule

// File: rtl/ledg_fade_driver.sv
// Green-LED PWM dimmer with optional linear fade (enable with macro LEDG_FADE_EN).
// Latency: in_port/brightness -> ledg 2 clks without fade; with fade, level moves one step per fade tick.
// Backpressure: none, free-running counters, inputs sampled every clock.
module ledg_fade_driver
    import ledg_pkg::*;
#(
    parameter int NUM_LEDS = LEDG_NUM_LEDS,
    parameter int LEVEL_W  = LEDG_LEVEL_W,
    parameter int PWM_DIV  = 4,
    parameter int FADE_DIV = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] in_port,
    input  logic [LEVEL_W-1:0]  brightness,
    output logic [NUM_LEDS-1:0] ledg
);

    localparam int                 DIV_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(PWM_DIV - 1);
    localparam logic [LEVEL_W-1:0] PWM_LAST = LEVEL_W'((1 << LEVEL_W) - 2);

    logic [DIV_W-1:0]   div_cnt_q;
    logic [LEVEL_W-1:0] pwm_cnt_q;
    logic               step;
    logic               frame_end;
    logic               fade_tick;

    assign step      = (div_cnt_q == DIV_LAST);
    assign frame_end = step && (pwm_cnt_q == PWM_LAST);

    // Prescaler: one PWM step every PWM_DIV clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else if (step) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    // PWM counter runs 0..LMAX-1 so that level LMAX compares as always-on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt_q <= '0;
        end else if (step) begin
            pwm_cnt_q <= frame_end ? '0 : pwm_cnt_q + 1'b1;
        end
    end

`ifdef LEDG_FADE_EN
    localparam int              FADE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV - 1);

    logic [FADE_W-1:0] fade_cnt_q;

    assign fade_tick = frame_end && (fade_cnt_q == FADE_LAST);

    // Fade counter: one level step every FADE_DIV PWM frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fade_cnt_q <= '0;
        end else if (frame_end) begin
            fade_cnt_q <= fade_tick ? '0 : fade_cnt_q + 1'b1;
        end
    end
`else
    localparam int unused_fade_div = FADE_DIV;
    assign fade_tick = 1'b0;
`endif

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        ledg_fade_channel #(
            .LEVEL_W (LEVEL_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .req        (in_port[i]),
            .brightness (brightness),
            .fade_tick  (fade_tick),
            .pwm_cnt    (pwm_cnt_q),
            .ledg       (ledg[i])
        );
    end

endmodule
